nco_freq_ramp: RTL and testbench
================================

// Module: nco_freq_ramp
// PURPOSE
//  Slew-rate-limited frequency controller for the NCO phase increment. Accepts a
//  target phase_inc over a valid/ready handshake and walks the NCO phase_inc toward
//  it by STEP every (rate_div+1) clocks. It ramps to zero when enable drops, so the
//  driver never sees a frequency step. It sits between the control registers and the
//  nco phase_inc input.
// PARAMETERS
//  PHASE_ACC_BITS  24  NCO accumulator width; phase_inc/target width is PHASE_ACC_BITS-1
//  STEP_BITS       16  width of the per-tick step magnitude
//  RATE_DIV_BITS   16  width of the tick prescaler divisor
// PORTS
//  clk        in   1                 system clock
//  rst        in   1                 asynchronous, active-low reset
//  enable     in   1                 1=run/accept targets; 0=ramp output to zero
//  tgt_inc    in   PHASE_ACC_BITS-1  requested phase increment (unsigned)
//  tgt_valid  in   1                 tgt_inc is valid
//  tgt_ready  out  1                 target can be accepted this cycle
//  step       in   STEP_BITS         increment change per tick (unsigned, live)
//  rate_div   in   RATE_DIV_BITS     tick every rate_div+1 clocks (live)
//  phase_inc  out  PHASE_ACC_BITS-1  registered increment driven to the nco
//  busy       out  1                 state != IDLE
//  at_target  out  1                 phase_inc == goal register
//  ramp_done  out  1                 one-cycle pulse when a ramp lands on its goal
// BEHAVIOUR
//  Reset (rst=0, async): phase_inc=0, goal=0, state=IDLE, tick cnt=0, ramp_done=0.
//   Resulting outputs: busy=0, at_target=1, tgt_ready=0 while rst is low.
//  States: IDLE (holding goal), RAMP (moving to the accepted target), STOP (moving to 0).
//  tgt_ready = enable & (state != STOP), combinational.
//   Targets are accepted in IDLE and mid-RAMP (retarget).
//  Accept (tgt_valid & tgt_ready at edge N): goal<=tgt_inc, cnt<=0, state<=RAMP.
//   A new goal overrides an old one mid-ramp. phase_inc continues from its current value.
//  Tick: in RAMP/STOP, tick=(cnt==rate_div); cnt<=tick?0:cnt+1. cnt is held at 0 in IDLE.
//  On tick, compute diff=|goal-phase_inc| in PHASE_ACC_BITS bits (no wrap):
//   - if step==0 or diff<=step: phase_inc<=goal, ramp_done<=1 for one cycle.
//     RAMP goes to IDLE; STOP goes to IDLE with goal=0.
//   - else phase_inc<=phase_inc+step if goal>phase_inc, otherwise phase_inc-step.
//   - Clamping guarantees phase_inc never overshoots the goal, never underflows
//     below 0 and never exceeds 2^(PHASE_ACC_BITS-1)-1.
//  Latency: the first phase_inc change is visible rate_div+2 cycles after the accept
//   edge. Later changes follow every rate_div+1 cycles.
//  A target equal to the current phase_inc still enters RAMP and completes on the
//   first tick, with ramp_done pulsing.
//  enable falls (any state): at the next edge goal<=0, cnt<=0, state<=STOP.
//   If phase_inc is already 0, the STOP still runs and completes on its first tick.
//   While enable=0 and state=IDLE, the block stays IDLE.
//  enable rises during STOP: state<=RAMP with goal=0 and tgt_ready=1.
//   A target accepted in the same cycle wins.
//  enable low and tgt_valid high in the same cycle: no accept, because tgt_ready=0.
//  step and rate_div are sampled only at tick or compare; changes mid-ramp take
//   effect on the next tick or prescaler compare.
//  Reset asserted mid-ramp: all state returns to the reset values immediately;
//   phase_inc=0 without ramping.
// TESTING
//  1. rate_div=0, step=100, accept tgt=1000 from 0.
//     -> phase_inc goes 100,200..1000 on consecutive cycles starting accept+2;
//        ramp_done pulses with 1000; busy falls next cycle.
//  2. rate_div=3, step=300, tgt=1000.
//     -> phase_inc 300,600,900,1000 spaced 4 cycles apart; no overshoot.
//  3. Ramp to 5000 (step=500, rate_div=0); at phase_inc=2000 accept tgt=1000.
//     -> phase_inc goes 1500,1000, then ramp_done; never exceeds 2000 after retarget.
//  4. Hold at 1200, drop enable with step=500, and drive tgt_valid the same cycle.
//     -> tgt_ready=0, no accept; phase_inc 700,200,0; ramp_done; IDLE with at_target=1.
//  5. step=0, tgt=2^23-1 from 0.
//     -> phase_inc=8388607 on the first tick; single ramp_done; no wrap.
//  6. Pull rst low mid-ramp at phase_inc=3000.
//     -> phase_inc=0, busy=0, tgt_ready=0 asynchronously; resumes accepting after release.

Source files
------------

// File: rtl/nco_freq_ramp.sv
// -----------------------------------------------------------------------------
// nco_freq_ramp
// Slew-rate-limited frequency controller for the NCO phase increment. A target
// increment arrives over a valid/ready handshake. The output increment then walks
// toward that target by i_step once every (i_rate_div+1) clocks. When i_enable
// drops, the output ramps down to zero so the NCO never sees a frequency step.
//
// Ports
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_enable     1 = run and accept targets, 0 = ramp the output to zero
//   i_tgt_inc    requested phase increment (unsigned, PHASE_ACC_BITS-1 wide)
//   i_tgt_valid  i_tgt_inc is valid
//   o_tgt_ready  a target can be accepted this cycle (combinational)
//   i_step       increment change per tick (live)
//   i_rate_div   a tick occurs every i_rate_div+1 clocks (live)
//   o_phase_inc  registered increment that drives the NCO
//   o_busy       state is not IDLE
//   o_at_target  o_phase_inc equals the goal register
//   o_ramp_done  one-cycle pulse when a ramp lands on its goal
// -----------------------------------------------------------------------------
module nco_freq_ramp #(
   parameter int PHASE_ACC_BITS = 24,
   parameter int STEP_BITS      = 16,
   parameter int RATE_DIV_BITS  = 16
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_enable,
   input  logic [PHASE_ACC_BITS-2:0]   i_tgt_inc,
   input  logic                        i_tgt_valid,
   output logic                        o_tgt_ready,
   input  logic [STEP_BITS-1:0]        i_step,
   input  logic [RATE_DIV_BITS-1:0]    i_rate_div,
   output logic [PHASE_ACC_BITS-2:0]   o_phase_inc,
   output logic                        o_busy,
   output logic                        o_at_target,
   output logic                        o_ramp_done
);

   localparam int W  = PHASE_ACC_BITS - 1;
   localparam int CW = (STEP_BITS > PHASE_ACC_BITS) ? STEP_BITS : PHASE_ACC_BITS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RAMP = 2'd1,
      STOP = 2'd2
   } rampState_t;

   rampState_t                 r_state;
   logic [W-1:0]               r_phaseInc;
   logic [W-1:0]               r_goal;
   logic [RATE_DIV_BITS-1:0]   r_cnt;
   logic                       r_tick;
   logic                       r_enableQ;
   logic                       r_rampDone;

   logic                       w_accept;
   logic                       w_enableFall;
   logic                       w_goalAbove;
   logic [CW-1:0]              w_diff;
   logic [CW-1:0]              w_stepExt;
   logic                       w_land;
   logic [W-1:0]               w_stepW;

   // The handshake is gated by reset so no target can be accepted while the
   // block is held in reset, and a stop in progress must finish before retargeting.
   always_comb begin
      o_tgt_ready  = i_rst_n & i_enable & (r_state != STOP);
      w_accept     = i_tgt_valid & o_tgt_ready;
      w_enableFall = r_enableQ & ~i_enable;
   end

   // Distance to the goal is formed one bit wider than the increment so the
   // subtraction cannot wrap; the tick lands on the goal when the remaining
   // distance fits inside one step (or the step is zero, meaning jump directly).
   always_comb begin
      w_goalAbove = r_goal > r_phaseInc;
      if (w_goalAbove) begin
         w_diff = CW'(r_goal) - CW'(r_phaseInc);
      end else begin
         w_diff = CW'(r_phaseInc) - CW'(r_goal);
      end
      w_stepExt = CW'(i_step);
      w_land    = (i_step == '0) || (w_diff <= w_stepExt);
      w_stepW   = W'(i_step);
   end

   // Main controller. The prescaler compare is registered into r_tick, so the
   // first increment change appears rate_div+2 clocks after an accept and then
   // every rate_div+1 clocks. A falling enable beats an accept, which beats a
   // pending tick; a retarget therefore holds the increment for that cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= IDLE;
         r_phaseInc <= '0;
         r_goal     <= '0;
         r_cnt      <= '0;
         r_tick     <= 1'b0;
         r_enableQ  <= 1'b0;
         r_rampDone <= 1'b0;
      end else begin
         r_enableQ  <= i_enable;
         r_rampDone <= 1'b0;
         if (w_enableFall) begin
            r_goal  <= '0;
            r_cnt   <= '0;
            r_tick  <= 1'b0;
            r_state <= STOP;
         end else if (w_accept) begin
            r_goal  <= i_tgt_inc;
            r_cnt   <= '0;
            r_tick  <= 1'b0;
            r_state <= RAMP;
         end else if (r_state != IDLE) begin
            r_tick <= (r_cnt == i_rate_div);
            r_cnt  <= (r_cnt == i_rate_div) ? '0 : r_cnt + 1'b1;
            if (r_tick && w_land) begin
               r_phaseInc <= r_goal;
               r_rampDone <= 1'b1;
               r_state    <= IDLE;
               r_cnt      <= '0;
               r_tick     <= 1'b0;
            end else begin
               if (r_tick) begin
                  r_phaseInc <= w_goalAbove ? (r_phaseInc + w_stepW)
                                            : (r_phaseInc - w_stepW);
               end
               if (r_state == STOP && i_enable) begin
                  r_state <= RAMP;
               end
            end
         end
      end
   end

   // Status outputs come straight from registered state.
   always_comb begin
      o_phase_inc = r_phaseInc;
      o_busy      = (r_state != IDLE);
      o_at_target = (r_phaseInc == r_goal);
      o_ramp_done = r_rampDone;
   end

endmodule

// File: tb/tb_nco_freq_ramp.sv
// -----------------------------------------------------------------------------
// tb_nco_freq_ramp
// Directed bench for nco_freq_ramp. Inputs change 1 ns after each rising edge
// and outputs are sampled at that same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_nco_freq_ramp;

   logic          clk;
   logic          rstN;
   logic          enable;
   logic [22:0]   tgtInc;
   logic          tgtValid;
   logic          tgtReady;
   logic [15:0]   step;
   logic [15:0]   rateDiv;
   logic [22:0]   phaseInc;
   logic          busy;
   logic          atTarget;
   logic          rampDone;

   int checks;
   int failures;

   nco_freq_ramp #(
      .PHASE_ACC_BITS (24),
      .STEP_BITS      (16),
      .RATE_DIV_BITS  (16)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rstN),
      .i_enable    (enable),
      .i_tgt_inc   (tgtInc),
      .i_tgt_valid (tgtValid),
      .o_tgt_ready (tgtReady),
      .i_step      (step),
      .i_rate_div  (rateDiv),
      .o_phase_inc (phaseInc),
      .o_busy      (busy),
      .o_at_target (atTarget),
      .o_ramp_done (rampDone)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and land 1 ns past the rising edge.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   // One comparison: count it, and on mismatch count and report the failure.
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Hold reset across one edge and release it 1 ns after an edge.
   task automatic pulseReset();
      rstN = 1'b0;
      applyStimulus();
      rstN = 1'b1;
      applyStimulus();
   endtask

   // Present a target for exactly one accepting edge.
   task automatic sendTarget(input logic [22:0] t);
      tgtInc   = t;
      tgtValid = 1'b1;
      applyStimulus();
      tgtValid = 1'b0;
   endtask

   initial begin
      logic [22:0] expVal;
      checks   = 0;
      failures = 0;
      rstN     = 1'b0;
      enable   = 1'b1;
      tgtInc   = '0;
      tgtValid = 1'b0;
      step     = 16'd100;
      rateDiv  = 16'd0;

      // Reset state, with enable high so ready must still be low.
      #2;
      checkOutput("rst_phase", 32'(phaseInc), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_at_target", 32'(atTarget), 32'd1);
      checkOutput("rst_ready", 32'(tgtReady), 32'd0);
      checkOutput("rst_done", 32'(rampDone), 32'd0);
      applyStimulus();
      rstN = 1'b1;
      applyStimulus();
      checkOutput("idle_ready", 32'(tgtReady), 32'd1);

      // 1: rate_div=0, step=100, 0 -> 1000; changes start accept+2.
      sendTarget(23'd1000);
      checkOutput("t1_accept_phase", 32'(phaseInc), 32'd0);
      checkOutput("t1_busy", 32'(busy), 32'd1);
      applyStimulus();
      checkOutput("t1_first_hold", 32'(phaseInc), 32'd0);
      for (int k = 1; k <= 10; k++) begin
         applyStimulus();
         checkOutput("t1_phase", 32'(phaseInc), 32'(k * 100));
         checkOutput("t1_done", 32'(rampDone), (k == 10) ? 32'd1 : 32'd0);
      end
      checkOutput("t1_at_target", 32'(atTarget), 32'd1);
      applyStimulus();
      checkOutput("t1_busy_after", 32'(busy), 32'd0);
      checkOutput("t1_done_after", 32'(rampDone), 32'd0);
      checkOutput("t1_phase_hold", 32'(phaseInc), 32'd1000);

      // 2: rate_div=3, step=300, 0 -> 1000; updates at accept+5,+9,+13,+17.
      pulseReset();
      rateDiv = 16'd3;
      step    = 16'd300;
      sendTarget(23'd1000);
      expVal = 23'd0;
      for (int c = 1; c <= 17; c++) begin
         applyStimulus();
         if (c == 5)  expVal = 23'd300;
         if (c == 9)  expVal = 23'd600;
         if (c == 13) expVal = 23'd900;
         if (c == 17) expVal = 23'd1000;
         checkOutput("t2_phase", 32'(phaseInc), 32'(expVal));
         checkOutput("t2_done", 32'(rampDone), (c == 17) ? 32'd1 : 32'd0);
      end

      // 3: ramp toward 5000 by 500, retarget to 1000 while at 2000.
      pulseReset();
      rateDiv = 16'd0;
      step    = 16'd500;
      sendTarget(23'd5000);
      applyStimulus();
      for (int k = 1; k <= 4; k++) begin
         applyStimulus();
         checkOutput("t3_up", 32'(phaseInc), 32'(k * 500));
      end
      sendTarget(23'd1000);
      checkOutput("t3_retarget_hold", 32'(phaseInc), 32'd2000);
      applyStimulus();
      checkOutput("t3_tick_hold", 32'(phaseInc), 32'd2000);
      applyStimulus();
      checkOutput("t3_down1", 32'(phaseInc), 32'd1500);
      checkOutput("t3_down1_done", 32'(rampDone), 32'd0);
      applyStimulus();
      checkOutput("t3_down2", 32'(phaseInc), 32'd1000);
      checkOutput("t3_down2_done", 32'(rampDone), 32'd1);

      // 4: hold at 1200, then drop enable with a target offered at once.
      sendTarget(23'd1200);
      applyStimulus();
      applyStimulus();
      checkOutput("t4_hold", 32'(phaseInc), 32'd1200);
      applyStimulus();
      enable   = 1'b0;
      tgtInc   = 23'd9999;
      tgtValid = 1'b1;
      #1;
      checkOutput("t4_ready_low", 32'(tgtReady), 32'd0);
      applyStimulus();
      checkOutput("t4_stop_busy", 32'(busy), 32'd1);
      checkOutput("t4_stop_hold", 32'(phaseInc), 32'd1200);
      applyStimulus();
      applyStimulus();
      checkOutput("t4_down1", 32'(phaseInc), 32'd700);
      applyStimulus();
      checkOutput("t4_down2", 32'(phaseInc), 32'd200);
      applyStimulus();
      checkOutput("t4_zero", 32'(phaseInc), 32'd0);
      checkOutput("t4_done", 32'(rampDone), 32'd1);
      applyStimulus();
      applyStimulus();
      checkOutput("t4_idle_busy", 32'(busy), 32'd0);
      checkOutput("t4_idle_at_target", 32'(atTarget), 32'd1);
      checkOutput("t4_no_accept", 32'(phaseInc), 32'd0);
      tgtValid = 1'b0;
      enable   = 1'b1;
      applyStimulus();

      // 5: step=0 jumps straight to full scale on the first tick.
      step = 16'd0;
      sendTarget(23'd8388607);
      applyStimulus();
      checkOutput("t5_before_tick", 32'(phaseInc), 32'd0);
      applyStimulus();
      checkOutput("t5_full_scale", 32'(phaseInc), 32'd8388607);
      checkOutput("t5_done", 32'(rampDone), 32'd1);
      applyStimulus();
      checkOutput("t5_single_done", 32'(rampDone), 32'd0);
      checkOutput("t5_no_wrap", 32'(phaseInc), 32'd8388607);
      checkOutput("t5_idle", 32'(busy), 32'd0);

      // 6: asynchronous reset mid-ramp at 3000, then accept again.
      pulseReset();
      step = 16'd1000;
      sendTarget(23'd5000);
      applyStimulus();
      for (int k = 1; k <= 3; k++) begin
         applyStimulus();
      end
      checkOutput("t6_mid", 32'(phaseInc), 32'd3000);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("t6_async_phase", 32'(phaseInc), 32'd0);
      checkOutput("t6_async_busy", 32'(busy), 32'd0);
      checkOutput("t6_async_ready", 32'(tgtReady), 32'd0);
      applyStimulus();
      rstN = 1'b1;
      applyStimulus();
      sendTarget(23'd200);
      applyStimulus();
      applyStimulus();
      checkOutput("t6_resume", 32'(phaseInc), 32'd200);
      checkOutput("t6_resume_done", 32'(rampDone), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
